cpr_sequencer: RTL and testbench

Schedules the CPR actuator once the monitor raises cpr_activate. Runs guideline cycles of COMPRESSIONS chest compressions followed by BREATHS ventilations. Pauses for a rhythm check every CYCLES_PER_CHECK cycles. Issues commands to a single shared actuator over a valid/ready handshake, timed by an external tick strobe.

---
 rtl/cpr_pkg.sv | 22 ++
 rtl/cpr_period_timer.sv | 28 ++
 rtl/cpr_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cpr_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpr_pkg.sv
// Shared state encoding, actuator command codes and default timing for the CPR sequencer.
package cpr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPRESS  = 3'd1,
        ST_VENTILATE = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DRAIN     = 3'd4
    } cpr_state_t;

    localparam logic CMD_COMPRESS  = 1'b0;
    localparam logic CMD_VENTILATE = 1'b1;

    localparam int DEF_COMPRESSIONS      = 30;
    localparam int DEF_BREATHS           = 2;
    localparam int DEF_COMP_PERIOD_TICKS = 6;
    localparam int DEF_BREATH_TICKS      = 10;
    localparam int DEF_CYCLES_PER_CHECK  = 5;
    localparam int DEF_CHECK_TICKS       = 100;

endpackage

// File: rtl/cpr_period_timer.sv
// Tick counter that pulses elapsed on the tick that completes a period and then wraps.
module cpr_period_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         restart,
    input  logic         tick,
    input  logic [W-1:0] period,
    output logic         elapsed
);

    logic [W-1:0] cnt;

    assign elapsed = tick && (cnt == period - W'(1));

    // restart wins over a coincident tick so a new period always begins at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || elapsed) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpr_sequencer.sv
// Schedules compression/ventilation commands to a shared actuator, with periodic rhythm-check pauses.
module cpr_sequencer
    import cpr_pkg::*;
#(
    parameter int COMPRESSIONS      = DEF_COMPRESSIONS,
    parameter int BREATHS           = DEF_BREATHS,
    parameter int COMP_PERIOD_TICKS = DEF_COMP_PERIOD_TICKS,
    parameter int BREATH_TICKS      = DEF_BREATH_TICKS,
    parameter int CYCLES_PER_CHECK  = DEF_CYCLES_PER_CHECK,
    parameter int CHECK_TICKS       = DEF_CHECK_TICKS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  tick,
    input  logic                                  cpr_activate,
    input  logic                                  act_ready,
    output logic                                  act_valid,
    output logic                                  act_cmd,
    output logic                                  rhythm_check,
    output logic                                  cpr_busy,
    output logic [$clog2(CYCLES_PER_CHECK+1)-1:0] cycle_count,
    output logic                                  overrun,
    output logic [2:0]                            state_o
);

    localparam int CW   = $clog2(COMPRESSIONS + 1);
    localparam int BW   = $clog2(BREATHS + 1);
    localparam int KW   = $clog2(CYCLES_PER_CHECK + 1);
    localparam int PMAX = (COMP_PERIOD_TICKS > BREATH_TICKS) ? COMP_PERIOD_TICKS : BREATH_TICKS;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = $clog2(CHECK_TICKS + 1);

    localparam logic [CW-1:0] COMP_N   = CW'(COMPRESSIONS);
    localparam logic [BW-1:0] BREATH_N = BW'(BREATHS);
    localparam logic [KW-1:0] CHECK_N  = KW'(CYCLES_PER_CHECK);

    cpr_state_t    state, state_nxt;
    logic          valid_nxt, cmd_nxt, overrun_nxt;
    logic          pending, pending_nxt;
    logic [CW-1:0] comp_cnt, comp_nxt, comp_inc;
    logic [BW-1:0] breath_cnt, breath_nxt, breath_inc;
    logic [KW-1:0] cycle_nxt;
    logic          accept, blocked, in_phase, fire;
    logic          phase_restart, phase_elapsed, check_restart, check_elapsed;
    logic [PW-1:0] phase_period;

    assign accept     = act_valid & act_ready;
    assign blocked    = act_valid & ~act_ready;
    assign in_phase   = (state == ST_COMPRESS) || (state == ST_VENTILATE);
    assign comp_inc   = comp_cnt + CW'(accept);
    assign breath_inc = breath_cnt + BW'(accept);
    // A period that elapsed behind a stalled command is replayed at the moment that command is taken.
    assign fire       = (phase_elapsed & ~blocked) | (pending & accept);

    assign phase_period  = (state == ST_VENTILATE) ? PW'(BREATH_TICKS) : PW'(COMP_PERIOD_TICKS);
    assign check_restart = (state != ST_CHECK);

    cpr_period_timer #(.W(PW)) u_phase_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (phase_restart),
        .tick    (tick),
        .period  (phase_period),
        .elapsed (phase_elapsed)
    );

    cpr_period_timer #(.W(TW)) u_check_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (check_restart),
        .tick    (tick),
        .period  (TW'(CHECK_TICKS)),
        .elapsed (check_elapsed)
    );

    always_comb begin
        state_nxt     = state;
        valid_nxt     = blocked;
        cmd_nxt       = act_cmd;
        comp_nxt      = comp_cnt;
        breath_nxt    = breath_cnt;
        cycle_nxt     = cycle_count;
        overrun_nxt   = overrun;
        pending_nxt   = pending;
        phase_restart = !in_phase;
        case (state)
            ST_IDLE: begin
                if (cpr_activate) begin
                    state_nxt  = ST_COMPRESS;
                    valid_nxt  = 1'b1;
                    cmd_nxt    = CMD_COMPRESS;
                    comp_nxt   = '0;
                    breath_nxt = '0;
                    cycle_nxt  = '0;
                end
            end
            ST_COMPRESS, ST_VENTILATE: begin
                if (!cpr_activate) begin
                    pending_nxt = 1'b0;
                    if (blocked) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt  = ST_IDLE;
                        comp_nxt   = '0;
                        breath_nxt = '0;
                        cycle_nxt  = '0;
                    end
                end else begin
                    if (state == ST_COMPRESS) comp_nxt = comp_inc;
                    else                      breath_nxt = breath_inc;
                    if (phase_elapsed && blocked) begin
                        overrun_nxt = 1'b1;
                        pending_nxt = 1'b1;
                    end
                    if (fire) begin
                        pending_nxt   = 1'b0;
                        phase_restart = 1'b1;
                        valid_nxt     = 1'b1;
                        if (state == ST_COMPRESS) begin
                            if (comp_inc == COMP_N) begin
                                state_nxt  = ST_VENTILATE;
                                cmd_nxt    = CMD_VENTILATE;
                                comp_nxt   = '0;
                                breath_nxt = '0;
                            end else begin
                                cmd_nxt = CMD_COMPRESS;
                            end
                        end else if (breath_inc == BREATH_N) begin
                            breath_nxt = '0;
                            cycle_nxt  = cycle_count + KW'(1);
                            if (cycle_count + KW'(1) == CHECK_N) begin
                                state_nxt = ST_CHECK;
                                valid_nxt = 1'b0;
                            end else begin
                                state_nxt = ST_COMPRESS;
                                cmd_nxt   = CMD_COMPRESS;
                            end
                        end else begin
                            cmd_nxt = CMD_VENTILATE;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (check_elapsed) begin
                    cycle_nxt = '0;
                    if (cpr_activate) begin
                        state_nxt = ST_COMPRESS;
                        valid_nxt = 1'b1;
                        cmd_nxt   = CMD_COMPRESS;
                        comp_nxt  = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    state_nxt  = ST_IDLE;
                    comp_nxt   = '0;
                    breath_nxt = '0;
                    cycle_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            act_valid   <= 1'b0;
            act_cmd     <= 1'b0;
            comp_cnt    <= '0;
            breath_cnt  <= '0;
            cycle_count <= '0;
            overrun     <= 1'b0;
            pending     <= 1'b0;
        end else begin
            state       <= state_nxt;
            act_valid   <= valid_nxt;
            act_cmd     <= cmd_nxt;
            comp_cnt    <= comp_nxt;
            breath_cnt  <= breath_nxt;
            cycle_count <= cycle_nxt;
            overrun     <= overrun_nxt;
            pending     <= pending_nxt;
        end
    end

    assign rhythm_check = (state == ST_CHECK);
    assign cpr_busy     = (state != ST_IDLE);
    assign state_o      = state;

endmodule

// File: tb/tb_cpr_sequencer.sv
// Directed and random stimulus against a command-schedule reference model of the CPR sequencer.
module tb_cpr_sequencer;

    localparam int C  = 3;
    localparam int B  = 2;
    localparam int CP = 2;
    localparam int BT = 3;
    localparam int K  = 2;
    localparam int CT = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_CHECK = 3;
    localparam int M_DRAIN = 4;

    logic       clk = 1'b0;
    logic       rst_n, tick, cpr_activate, act_ready;
    logic       act_valid, act_cmd, rhythm_check, cpr_busy, overrun;
    logic [1:0] cycle_count;
    logic [2:0] state_o;

    cpr_sequencer #(
        .COMPRESSIONS      (C),
        .BREATHS           (B),
        .COMP_PERIOD_TICKS (CP),
        .BREATH_TICKS      (BT),
        .CYCLES_PER_CHECK  (K),
        .CHECK_TICKS       (CT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .cpr_activate (cpr_activate),
        .act_ready    (act_ready),
        .act_valid    (act_valid),
        .act_cmd      (act_cmd),
        .rhythm_check (rhythm_check),
        .cpr_busy     (cpr_busy),
        .cycle_count  (cycle_count),
        .overrun      (overrun),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_acc0 = 0;
    int n_acc1 = 0;
    logic [0:0] exp_q[$];

    // Reference: a cycle is a fixed schedule of C compress slots then B ventilate slots.
    int m_mode, m_pos, m_ticks, m_chk, m_cycles;
    bit m_valid, m_cmd, m_late, m_overrun;

    function automatic int period_of(input int pos);
        return (pos < C) ? CP : BT;
    endfunction

    function automatic int m_state();
        if (m_mode == M_RUN) return (m_pos < C) ? 1 : 2;
        return m_mode;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit a, input bit rd, input bit t);
        bit acc, due, blk, go;
        if (!r) begin
            m_mode = M_IDLE; m_pos = 0; m_ticks = 0; m_chk = 0; m_cycles = 0;
            m_valid = 0; m_cmd = 0; m_late = 0; m_overrun = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (a) begin
                    m_mode = M_RUN; m_pos = 0; m_valid = 1; m_cmd = 0; m_ticks = 0; m_cycles = 0;
                end
                M_RUN: begin
                    acc = m_valid && rd;
                    if (!a) begin
                        m_late = 0;
                        if (m_valid && !acc) m_mode = M_DRAIN;
                        else begin m_mode = M_IDLE; m_valid = 0; m_cycles = 0; end
                    end else begin
                        due = t && (m_ticks + 1 == period_of(m_pos));
                        blk = m_valid && !acc;
                        m_ticks = due ? 0 : m_ticks + int'(t);
                        if (acc) m_valid = 0;
                        go = (due && !blk) || (m_late && acc);
                        if (due && blk) begin m_overrun = 1; m_late = 1; end
                        if (go) begin
                            m_late = 0; m_ticks = 0; m_pos++;
                            if (m_pos == C + B) begin
                                m_pos = 0; m_cycles++;
                                if (m_cycles == K) begin m_mode = M_CHECK; m_chk = 0; end
                            end
                            if (m_mode == M_RUN) begin m_valid = 1; m_cmd = (m_pos >= C); end
                        end
                    end
                end
                M_CHECK: if (t) begin
                    m_chk++;
                    if (m_chk == CT) begin
                        m_cycles = 0;
                        if (a) begin m_mode = M_RUN; m_pos = 0; m_valid = 1; m_cmd = 0; m_ticks = 0; end
                        else m_mode = M_IDLE;
                    end
                end
                M_DRAIN: if (rd) begin m_mode = M_IDLE; m_valid = 0; m_cycles = 0; end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // Drives one cycle: compare outputs to the model, score acceptances, advance model and clock.
    task automatic do_cycle(input bit r, input bit a, input bit rd, input bit t);
        rst_n = r; cpr_activate = a; act_ready = rd; tick = t;
        check("state", 32'(state_o), 32'(m_state()));
        check("valid", 32'(act_valid), 32'(m_valid));
        if (m_valid) check("cmd", 32'(act_cmd), 32'(m_cmd));
        check("busy", 32'(cpr_busy), 32'(m_mode != M_IDLE));
        check("rhythm", 32'(rhythm_check), 32'(m_mode == M_CHECK));
        check("cycles", 32'(cycle_count), 32'(m_cycles));
        check("overrun", 32'(overrun), 32'(m_overrun));
        if (r && m_valid && rd) exp_q.push_back(m_cmd);
        if (r && act_valid && rd) begin
            if (act_cmd) n_acc1++; else n_acc0++;
            if (exp_q.size() == 0) check("accept_expected", 32'(1), 32'(0));
            else check("accept_cmd", 32'(act_cmd), 32'(exp_q.pop_front()));
        end
        model_step(r, a, rd, t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1;
        bit a_r;
        rst_n = 0; tick = 0; cpr_activate = 0; act_ready = 0;
        model_step(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // reset and idle
        for (int i = 0; i < 6; i++) do_cycle(1, 0, 1'($urandom_range(0, 1)), 1);
        check("idle_state", 32'(state_o), 0);
        check("idle_valid", 32'(act_valid), 0);

        // two full cycles, rhythm check, resume
        a0 = n_acc0; a1 = n_acc1;
        for (int i = 0; i < 13; i++) do_cycle(1, 1, 1, 1);
        check("cycle1_count", 32'(cycle_count), 1);
        check("cycle1_comp", 32'(n_acc0 - a0), 3);
        check("cycle1_vent", 32'(n_acc1 - a1), 2);
        for (int i = 0; i < 12; i++) do_cycle(1, 1, 1, 1);
        check("check_state", 32'(state_o), 3);
        check("check_flag", 32'(rhythm_check), 1);
        for (int i = 0; i < 4; i++) do_cycle(1, 1, 1, 1);
        check("resume_state", 32'(state_o), 1);
        check("resume_count", 32'(cycle_count), 0);

        // check ends with activation withdrawn
        for (int i = 0; i < 24; i++) do_cycle(1, 1, 1, 1);
        check("check2_state", 32'(state_o), 3);
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 1, 1);
        check("chk_idle_state", 32'(state_o), 0);
        check("chk_idle_busy", 32'(cpr_busy), 0);
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 1, 1);
        check("chk_idle_valid", 32'(act_valid), 0);

        // backpressure on the first compression
        do_cycle(0, 0, 0, 1);
        a0 = n_acc0; a1 = n_acc1;
        for (int i = 0; i < 6; i++) do_cycle(1, 1, 0, 1);
        check("bp_valid", 32'(act_valid), 1);
        check("bp_cmd", 32'(act_cmd), 0);
        check("bp_overrun", 32'(overrun), 1);
        for (int i = 0; i < 6; i++) do_cycle(1, 1, 1, 1);
        check("bp_comp", 32'(n_acc0 - a0), 3);
        check("bp_vent", 32'(n_acc1 - a1), 1);

        // abort while a command is stalled
        for (int i = 0; i < 20 && !m_valid; i++) do_cycle(1, 1, 0, 1);
        check("abort_setup", 32'(act_valid), 1);
        do_cycle(1, 0, 0, 1);
        check("drain_state", 32'(state_o), 4);
        a0 = n_acc0 + n_acc1;
        do_cycle(1, 0, 1, 1);
        check("drain_idle", 32'(state_o), 0);
        check("drain_accepts", 32'(n_acc0 + n_acc1 - a0), 1);

        // reset during ventilation with a command outstanding
        for (int i = 0; i < 30 && !(m_state() == 2 && m_valid); i++) do_cycle(1, 1, 1, 1);
        check("rst_setup", 32'(state_o), 2);
        check("rst_overrun_sticky", 32'(overrun), 1);
        do_cycle(0, 1, 1, 1);
        check("rst_state", 32'(state_o), 0);
        check("rst_valid", 32'(act_valid), 0);
        check("rst_busy", 32'(cpr_busy), 0);
        check("rst_overrun", 32'(overrun), 0);

        // random traffic
        a_r = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) a_r = !a_r;
            do_cycle($urandom_range(0, 249) != 0, a_r, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 1) == 1);
        end
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
